seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter: emits a programmed bit sequence, or a pseudo-random stream, one bit per clock on a single serial line. It is the driving end of the serial input consumed by the lab's Mealy sequence detectors. It replaces hand-written stimulus loops with a synthesizable source that can feed a detector directly in simulation or on the board. A start/busy/done handshake allows a controller or bench to sequence transmissions.

## Interface
- WIDTH, 16, pattern register width in bits; must be ≥ 16 because the LFSR seed is taken from pattern[15:0]
- IDXW, 5, width of len and bit_idx; must satisfy 2**IDXW > WIDTH
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin transmission; sampled only in IDLE
- mode  in  1  0 = pattern mode, 1 = LFSR mode; latched on start
- pattern  in  WIDTH  bits to send, LSB first (pattern mode), or LFSR seed in pattern[15:0] (LFSR mode); latched on start
- len  in  IDXW  bits per pass, 1..WIDTH; 0 or any value > WIDTH is treated as WIDTH; latched on start
- repeat_en  in  1  sampled live at end of each pass; 1 = start another pass
- stop  in  1  synchronous abort
- outp  out  1  serial data bit
- out_valid  out  1  outp is a valid data bit this cycle
- busy  out  1  high in SEND
- done  out  1  one-cycle pulse after a pass that is not repeated
- bit_idx  out  IDXW  index within the pass of the bit currently on outp

## Operation
- States: IDLE, SEND, DONE. All outputs are registered.
- Reset (rst = 0, asynchronous):
  - state = IDLE; outp, out_valid, busy, done = 0; bit_idx = 0; shift register = 0; LFSR = 16'hACE1.
- IDLE:
  - On an edge with start = 1: latch mode, pattern and the effective len.
  - Pattern mode: shift register ← pattern.
  - LFSR mode: LFSR ← pattern[15:0], or 16'hACE1 if that seed is 0.
  - Go to SEND. In the same edge: outp = first bit, out_valid = 1, busy = 1, bit_idx = 0.
- SEND:
  - Each edge presents the next bit and increments bit_idx.
  - Pattern mode: outp = shreg[bit_idx], i.e. LSB first.
  - LFSR mode (Fibonacci, x^16+x^14+x^13+x^11+1):
    - outp = lfsr[0]
    - fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5]
    - lfsr ← {fb, lfsr[15:1]}
- End of pass (edge where bit_idx = len−1 is on outp):
  - If repeat_en = 1: bit_idx ← 0 and stay in SEND.
    - Pattern mode restarts from bit 0 of the latched pattern.
    - LFSR mode continues the sequence with no reseed.
  - If repeat_en = 0: go to DONE; outp ← 0, out_valid ← 0, busy ← 0, done ← 1.
- DONE: lasts one cycle; done ← 0; go to IDLE.
- stop = 1 in SEND or DONE:
  - Next edge → IDLE; outp, out_valid, busy, done ← 0; no done pulse.
  - stop takes priority over end-of-pass and repeat_en.
- stop and start both high in IDLE: start wins.
- start in SEND or DONE is ignored. Changes to pattern, len or mode there have no effect.
- Mid-operation reset: immediate return to reset values; the latched pattern is discarded.

## Timing
- Latency: first bit is valid the cycle after the start edge, i.e. visible right after that edge.
- A single pass of len bits: out_valid is high for exactly len consecutive cycles; done is high in the next cycle; busy is low from that cycle on.
- Next start is accepted at the edge after done, so done to next first bit is 2 cycles minimum.
- Repeat: no bubble; bit len−1 is followed directly by bit 0, and out_valid stays high.
- The consuming detector samples outp on the same clk edge; one bit is advanced per edge.

## Test plan
- Pattern 16'b0101_0111_0111_0010, len 0, mode 0, start pulse:
  - outp = 0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0 on 16 valid cycles, bit_idx 0..15.
  - Then done pulse; busy falls.
- len = 3, pattern 16'h0005, repeat_en held 1 for 2 passes, then 0:
  - outp 1,0,1,1,0,1,1,0,1 with continuous out_valid.
  - Then done; 9 valid cycles total.
- LFSR mode, seed 16'h0001:
  - First outp = 1; internal LFSR = 16'h8000 after the first shift.
  - Next three bits 0,0,0.
  - Seed 0 yields the same stream as seed 16'hACE1.
- stop asserted at bit_idx = 5:
  - Next edge: out_valid = 0, busy = 0, no done pulse, state IDLE.
  - New start accepted on the following edge.
- start pulsed at bit_idx 2 of a len-8 pass, with pattern changed: output stream unchanged.
- rst driven low at bit_idx 7, asynchronously between edges:
  - All outputs go to 0 immediately.
  - After release, no output until a new start.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial transmitter sending a latched pattern (LSB first) or a 16-bit LFSR stream, one bit per clock.
// Ports: clk / rst (async, active-low); start, mode, pattern, len are latched on start in IDLE;
// repeat_en is sampled at each end of pass; stop aborts to IDLE.
// Outputs (all registered): outp, out_valid, busy, done (one-cycle pulse), bit_idx.
module seq_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] pattern,
    input  logic [IDXW-1:0]  len,
    input  logic             repeat_en,
    input  logic             stop,
    output logic             outp,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [IDXW-1:0]  bit_idx
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [15:0]      lfsr_q, lfsr_d, seed;
    logic             mode_q, mode_d;
    logic [IDXW-1:0]  len_q, len_d, idx_q, idx_d, idx_nx;
    logic             outp_q, outp_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // The start edge already emits bit 0, so the LFSR is loaded one step ahead of the seed.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        lfsr_d  = lfsr_q;
        mode_d  = mode_q;
        len_d   = len_q;
        idx_d   = idx_q;
        outp_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        seed    = (pattern[15:0] == 16'h0) ? 16'hACE1 : pattern[15:0];
        idx_nx  = (idx_q == len_q - 1'b1) ? '0 : idx_q + 1'b1;
        case (state_q)
            IDLE: if (start) begin
                state_d = SEND;
                mode_d  = mode;
                len_d   = (len == '0 || len > IDXW'(WIDTH)) ? IDXW'(WIDTH) : len;
                shreg_d = pattern;
                idx_d   = '0;
                outp_d  = mode ? seed[0] : pattern[0];
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (mode) lfsr_d = lfsr_step(seed);
            end
            SEND: if (stop) begin
                state_d = IDLE;
            end else if (idx_q == len_q - 1'b1 && !repeat_en) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_nx;
                outp_d  = mode_q ? lfsr_q[0] : |(shreg_q & (WIDTH'(1) << idx_nx));
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (mode_q) lfsr_d = lfsr_step(lfsr_q);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            lfsr_q  <= 16'hACE1;
            mode_q  <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            outp_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            outp_q  <= outp_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign outp      = outp_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_idx   = idx_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed self-checking bench for seq_pattern_tx.
module tb_seq_pattern_tx;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0, repeat_en = 1'b0, stop = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic        outp, out_valid, busy, done;
    logic [4:0]  bit_idx;
    logic [15:0] v, m;
    int          tests = 0, fails = 0;

    seq_pattern_tx dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .pattern(pattern), .len(len),
        .repeat_en(repeat_en), .stop(stop), .outp(outp), .out_valid(out_valid),
        .busy(busy), .done(done), .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic b, input int idx);
        chk({tag, " outp"}, outp, b);
        chk({tag, " valid"}, out_valid, 1'b1);
        chk({tag, " busy"}, busy, 1'b1);
        chk({tag, " bit_idx"}, bit_idx, idx);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " valid_low"}, out_valid, 1'b0);
        chk({tag, " busy_low"}, busy, 1'b0);
        chk({tag, " outp_low"}, outp, 1'b0);
        tick;
        chk({tag, " done_drop"}, done, 1'b0);
    endtask

    task automatic kick(input logic md, input logic [15:0] p, input logic [4:0] l);
        mode = md;
        pattern = p;
        len = l;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        tick;
        chk("rst outp", outp, 1'b0);
        chk("rst valid", out_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst idx", bit_idx, 5'd0);
        rst = 1'b1;
        tick;
        chk("idle valid", out_valid, 1'b0);

        v = 16'b0101_0111_0111_0010;
        kick(1'b0, v, 5'd0);
        for (int i = 0; i < 16; i++) begin
            chk_bit("pat16", v[i], i);
            tick;
        end
        chk_done("pat16");

        v = 16'b101_101_101;
        repeat_en = 1'b1;
        kick(1'b0, 16'h0005, 5'd3);
        for (int i = 0; i < 9; i++) begin
            chk_bit("rep3", v[8-i], i % 3);
            if (i == 6) repeat_en = 1'b0;
            tick;
        end
        chk_done("rep3");

        kick(1'b1, 16'h0001, 5'd4);
        chk("lfsr1 state", dut.lfsr_q, 16'h8000);
        v = 16'b0001;
        for (int i = 0; i < 4; i++) begin
            chk_bit("lfsr1", v[i], i);
            tick;
        end
        chk_done("lfsr1");

        m = 16'hACE1;
        kick(1'b1, 16'h0000, 5'd0);
        for (int i = 0; i < 16; i++) begin
            chk_bit("seed0", m[0], i);
            m = lstep(m);
            tick;
        end
        chk_done("seed0");
        m = 16'hACE1;
        kick(1'b1, 16'hACE1, 5'd20);
        for (int i = 0; i < 16; i++) begin
            chk_bit("seedace1", m[0], i);
            m = lstep(m);
            tick;
        end
        chk_done("seedace1");

        kick(1'b0, 16'hFFFF, 5'd0);
        for (int i = 0; i < 5; i++) tick;
        chk("stop at idx", bit_idx, 5'd5);
        stop = 1'b1;
        tick;
        chk("stop valid", out_valid, 1'b0);
        chk("stop busy", busy, 1'b0);
        chk("stop done", done, 1'b0);
        start = 1'b1;
        tick;
        start = 1'b0;
        stop = 1'b0;
        chk_bit("restart", 1'b1, 0);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("stop2 valid", out_valid, 1'b0);
        tick;
        chk("stop2 no done", done, 1'b0);

        v = 16'h00B4;
        kick(1'b0, v, 5'd8);
        for (int i = 0; i < 8; i++) begin
            chk_bit("ign", v[i], i);
            if (i == 2) begin
                start = 1'b1;
                pattern = 16'hFFFF;
                mode = 1'b1;
                len = 5'd3;
            end
            tick;
            start = 1'b0;
        end
        chk_done("ign");

        kick(1'b0, 16'hFFFF, 5'd0);
        for (int i = 0; i < 7; i++) tick;
        chk("arst idx", bit_idx, 5'd7);
        #2 rst = 1'b0;
        #1;
        chk("arst outp", outp, 1'b0);
        chk("arst valid", out_valid, 1'b0);
        chk("arst busy", busy, 1'b0);
        chk("arst idx0", bit_idx, 5'd0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post arst valid", out_valid, 1'b0);
            chk("post arst busy", busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
